// File: rtl/conv_window_builder_pkg.sv
// Shared widths, FSM encoding and helpers for the 3x3 convolution window builder.
// No logic or latency here; imported by the interface, the shift register and the top.
package conv_window_builder_pkg;

    localparam int NB_DATA    = 8;
    localparam int N_CONV     = 4;
    localparam int N_ROWS     = N_CONV + 2;
    localparam int NB_IMAGE   = 10;
    localparam int WIN_SIZE   = 9;
    localparam int NB_SLICE   = N_ROWS * NB_DATA;
    localparam int NB_WIN     = WIN_SIZE * NB_DATA;
    localparam int NB_WINDOWS = N_CONV * NB_WIN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [NB_IMAGE-1:0] sat_inc(input logic [NB_IMAGE-1:0] v);
        return (&v) ? v : v + NB_IMAGE'(1);
    endfunction

endpackage

// File: rtl/conv_window_builder_if.sv
// Slice-in / windows-out bundle between the address FSM, the window builder and the convolvers.
// Valid-only: the builder accepts every slice, so there is no ready path.
interface conv_window_builder_if;
    import conv_window_builder_pkg::*;

    logic                  i_vld;
    logic                  i_changeBlock;
    logic                  i_EoP;
    logic [NB_IMAGE-1:0]   i_imgLength;
    logic [NB_SLICE-1:0]   i_data;
    logic [NB_WINDOWS-1:0] o_window;
    logic                  o_winVld;
    logic [NB_IMAGE-1:0]   o_colCount;
    logic                  o_blockDone;

    modport master (
        output i_vld, i_changeBlock, i_EoP, i_imgLength, i_data,
        input  o_window, o_winVld, o_colCount, o_blockDone
    );

    modport slave (
        input  i_vld, i_changeBlock, i_EoP, i_imgLength, i_data,
        output o_window, o_winVld, o_colCount, o_blockDone
    );

endinterface

// File: rtl/conv_window_builder_col_shreg.sv
// Three-column shift register of image slices; col0 oldest, col2 newest.
// Updates on the clock after en/clr; clr with en loads din into a cleared register.
module conv_col_shreg
    import conv_window_builder_pkg::*;
#(
    parameter int W = NB_SLICE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] col0,
    output logic [W-1:0] col1,
    output logic [W-1:0] col2
);

    logic [W-1:0] col0_q, col0_d;
    logic [W-1:0] col1_q, col1_d;
    logic [W-1:0] col2_q, col2_d;

    always_comb begin
        col0_d = col0_q;
        col1_d = col1_q;
        col2_d = col2_q;
        if (en) begin
            col0_d = clr ? '0 : col1_q;
            col1_d = clr ? '0 : col2_q;
            col2_d = din;
        end else if (clr) begin
            col0_d = '0;
            col1_d = '0;
            col2_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col0_q <= '0;
            col1_q <= '0;
            col2_q <= '0;
        end else begin
            col0_q <= col0_d;
            col1_q <= col1_d;
            col2_q <= col2_d;
        end
    end

    assign col0 = col0_q;
    assign col1 = col1_q;
    assign col2 = col2_q;

endmodule

// File: rtl/conv_window_builder.sv
// Builds N_CONV parallel 3x3 windows from a sliding 3-column register of image slices.
// Window registered 1 cycle after the completing slice; no backpressure, every slice is consumed.
module conv_window_builder
    import conv_window_builder_pkg::*;
(
    input  logic                  i_CLK,
    input  logic                  i_reset,
    conv_window_builder_if.slave  bus
);

    state_t                state_q, state_d;
    logic [1:0]            fill_q, fill_d;
    logic [NB_IMAGE-1:0]   cnt_q, cnt_d;
    logic [NB_IMAGE-1:0]   len_q, len_d;
    logic [NB_WINDOWS-1:0] window_q, window_d;
    logic                  win_vld_q, win_vld_d;
    logic                  block_done_q, block_done_d;

    logic                  sh_en, sh_clr;
    logic                  vld_eff, cb_eff, new_blk, last_col;
    logic [NB_SLICE-1:0]   col_mid, col_new, oldest_col_unused;
    logic [2:0][NB_SLICE-1:0] col_nx;
    logic [NB_WINDOWS-1:0] win_nx;

    // The oldest stored column is shifted out before any window reads it.
    conv_col_shreg #(.W(NB_SLICE)) u_shreg (
        .clk   (i_CLK),
        .rst_n (i_reset),
        .clr   (sh_clr),
        .en    (sh_en),
        .din   (bus.i_data),
        .col0  (oldest_col_unused),
        .col1  (col_mid),
        .col2  (col_new)
    );

    // Columns as they will stand after this cycle's shift.
    assign col_nx[0] = col_mid;
    assign col_nx[1] = col_new;
    assign col_nx[2] = bus.i_data;

    for (genvar k = 0; k < N_CONV; k++) begin : g_conv
        for (genvar r = 0; r < 3; r++) begin : g_row
            for (genvar c = 0; c < 3; c++) begin : g_col
                assign win_nx[k*NB_WIN + (r*3+c)*NB_DATA +: NB_DATA] =
                    col_nx[c][(k+r)*NB_DATA +: NB_DATA];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        window_d     = window_q;
        win_vld_d    = 1'b0;
        block_done_d = 1'b0;
        sh_en        = 1'b0;
        sh_clr       = 1'b0;
        last_col     = 1'b0;

        // End of picture overrides a block change and swallows a slice arriving in DONE.
        vld_eff = bus.i_vld && !(bus.i_EoP && state_q == ST_DONE);
        cb_eff  = bus.i_changeBlock && !bus.i_EoP;
        new_blk = cb_eff || state_q == ST_IDLE || state_q == ST_DONE;

        if (cb_eff) begin
            fill_d  = 2'd0;
            cnt_d   = '0;
            sh_clr  = 1'b1;
            state_d = ST_IDLE;
        end

        if (vld_eff) begin
            sh_en = 1'b1;
            if (new_blk) begin
                sh_clr   = 1'b1;
                fill_d   = 2'd1;
                cnt_d    = NB_IMAGE'(1);
                len_d    = bus.i_imgLength;
                last_col = (bus.i_imgLength == '0);
            end else begin
                fill_d   = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
                cnt_d    = sat_inc(cnt_q);
                last_col = (cnt_q == len_q);
                if (fill_d == 2'd3) begin
                    win_vld_d = 1'b1;
                    window_d  = win_nx;
                end
            end

            if (last_col) begin
                state_d      = ST_DONE;
                block_done_d = 1'b1;
            end else begin
                state_d = (fill_d == 2'd3) ? ST_STREAM : ST_FILL;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end

        if (bus.i_EoP) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            fill_q       <= 2'd0;
            cnt_q        <= '0;
            len_q        <= '0;
            window_q     <= '0;
            win_vld_q    <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            window_q     <= window_d;
            win_vld_q    <= win_vld_d;
            block_done_q <= block_done_d;
        end
    end

    assign bus.o_window    = window_q;
    assign bus.o_winVld    = win_vld_q;
    assign bus.o_colCount  = cnt_q;
    assign bus.o_blockDone = block_done_q;

endmodule

// File: tb/tb_conv_window_builder.sv
// Directed bench for conv_window_builder: pixels are {col[3:0], row[3:0]}.
module tb_conv_window_builder;
    import conv_window_builder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    conv_window_builder_if bus();

    conv_window_builder dut (
        .i_CLK   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    function automatic logic [NB_SLICE-1:0] mk_slice(input int col);
        logic [NB_SLICE-1:0] s;
        logic [3:0] c4, r4;
        s  = '0;
        c4 = 4'(col);
        for (int j = 0; j < N_ROWS; j++) begin
            r4 = 4'(j);
            s[j*NB_DATA +: NB_DATA] = {c4, r4};
        end
        return s;
    endfunction

    // Expected window of convolver k whose oldest column is c0.
    function automatic logic [NB_WIN-1:0] exp_win(input int k, input int c0);
        logic [NB_WIN-1:0] w;
        logic [3:0] c4, r4;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                c4 = 4'(c0 + c);
                r4 = 4'(k + r);
                w[(r*3+c)*NB_DATA +: NB_DATA] = {c4, r4};
            end
        end
        return w;
    endfunction

    task automatic drive(input logic vld, input logic cb, input logic eop, input int col);
        bus.i_vld         = vld;
        bus.i_changeBlock = cb;
        bus.i_EoP         = eop;
        bus.i_data        = mk_slice(col);
        @(posedge clk);
        #1;
        bus.i_vld         = 1'b0;
        bus.i_changeBlock = 1'b0;
        bus.i_EoP         = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        logic exp_v;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.o_window !== '0) begin n_fail++; $display("FAIL reset_window: got %h want 0", bus.o_window); end
        n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL reset_winvld: got %b want 0", bus.o_winVld); end
        n_tests++; if (bus.o_colCount !== '0) begin n_fail++; $display("FAIL reset_colcount: got %0d want 0", bus.o_colCount); end
        n_tests++; if (bus.o_blockDone !== 1'b0) begin n_fail++; $display("FAIL reset_blockdone: got %b want 0", bus.o_blockDone); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, i);
        n_tests++; if (bus.o_winVld !== 1'b1) begin n_fail++; $display("FAIL prereset_winvld: got %b want 1", bus.o_winVld); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.o_window !== '0) begin n_fail++; $display("FAIL midreset_window: got %h want 0", bus.o_window); end
        n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL midreset_winvld: got %b want 0", bus.o_winVld); end
        n_tests++; if (bus.o_colCount !== '0) begin n_fail++; $display("FAIL midreset_colcount: got %0d want 0", bus.o_colCount); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, i);
            exp_v = (i == 2);
            n_tests++; if (bus.o_winVld !== exp_v) begin n_fail++; $display("FAIL postreset_winvld[%0d]: got %b want %b", i, bus.o_winVld, exp_v); end
        end
        n_tests++; if (bus.o_window[0 +: NB_WIN] !== exp_win(0, 0)) begin n_fail++; $display("FAIL postreset_win0: got %h want %h", bus.o_window[0 +: NB_WIN], exp_win(0, 0)); end
        drive(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_basic();
        logic exp_v, exp_d;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, i);
            exp_v = (i >= 2);
            exp_d = (i == 4);
            n_tests++; if (bus.o_winVld !== exp_v) begin n_fail++; $display("FAIL basic_winvld[%0d]: got %b want %b", i, bus.o_winVld, exp_v); end
            n_tests++; if (bus.o_blockDone !== exp_d) begin n_fail++; $display("FAIL basic_blockdone[%0d]: got %b want %b", i, bus.o_blockDone, exp_d); end
            if (i == 2) begin
                n_tests++; if (bus.o_window[0 +: NB_WIN] !== exp_win(0, 0)) begin n_fail++; $display("FAIL basic_first_win0: got %h want %h", bus.o_window[0 +: NB_WIN], exp_win(0, 0)); end
                n_tests++; if (bus.o_window[3*NB_WIN +: NB_WIN] !== exp_win(3, 0)) begin n_fail++; $display("FAIL basic_first_win3: got %h want %h", bus.o_window[3*NB_WIN +: NB_WIN], exp_win(3, 0)); end
            end
            if (i == 4) begin
                n_tests++; if (bus.o_colCount !== NB_IMAGE'(5)) begin n_fail++; $display("FAIL basic_colcount: got %0d want 5", bus.o_colCount); end
                n_tests++; if (bus.o_window[2*NB_WIN +: NB_WIN] !== exp_win(2, 2)) begin n_fail++; $display("FAIL basic_last_win2: got %h want %h", bus.o_window[2*NB_WIN +: NB_WIN], exp_win(2, 2)); end
            end
            idle();
            n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL basic_gap_winvld[%0d]: got %b want 0", i, bus.o_winVld); end
            n_tests++; if (bus.o_blockDone !== 1'b0) begin n_fail++; $display("FAIL basic_gap_blockdone[%0d]: got %b want 0", i, bus.o_blockDone); end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] wmask, dmask;
        int col;
        wmask = '0;
        dmask = '0;
        for (int i = 0; i < 10; i++) begin
            col = (i < 5) ? i : i + 3;
            drive(1'b1, 1'b0, 1'b0, col);
            wmask[i] = bus.o_winVld;
            dmask[i] = bus.o_blockDone;
            if (i == 7) begin
                n_tests++; if (bus.o_window[0 +: NB_WIN] !== exp_win(0, 8)) begin n_fail++; $display("FAIL b2b_block2_win0: got %h want %h", bus.o_window[0 +: NB_WIN], exp_win(0, 8)); end
            end
        end
        n_tests++; if (wmask !== 10'b1110011100) begin n_fail++; $display("FAIL b2b_window_pattern: got %b want 1110011100", wmask); end
        n_tests++; if (dmask !== 10'b1000010000) begin n_fail++; $display("FAIL b2b_done_pattern: got %b want 1000010000", dmask); end
        idle();
    endtask

    task automatic test_change_block();
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 1);
        n_tests++; if (bus.o_colCount !== NB_IMAGE'(1)) begin n_fail++; $display("FAIL cb_colcount: got %0d want 1", bus.o_colCount); end
        drive(1'b1, 1'b0, 1'b0, 2);
        n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL cb_early_winvld: got %b want 0", bus.o_winVld); end
        n_tests++; if (bus.o_colCount !== NB_IMAGE'(2)) begin n_fail++; $display("FAIL cb_colcount2: got %0d want 2", bus.o_colCount); end
        drive(1'b1, 1'b0, 1'b0, 3);
        n_tests++; if (bus.o_winVld !== 1'b1) begin n_fail++; $display("FAIL cb_winvld: got %b want 1", bus.o_winVld); end
        n_tests++; if (bus.o_window[NB_WIN +: NB_WIN] !== exp_win(1, 1)) begin n_fail++; $display("FAIL cb_win1: got %h want %h", bus.o_window[NB_WIN +: NB_WIN], exp_win(1, 1)); end
        drive(1'b0, 1'b1, 1'b0, 0);
        n_tests++; if (bus.o_colCount !== '0) begin n_fail++; $display("FAIL cb_clear_colcount: got %0d want 0", bus.o_colCount); end
        n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL cb_clear_winvld: got %b want 0", bus.o_winVld); end
    endtask

    task automatic test_eop();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, i);
        drive(1'b1, 1'b0, 1'b1, 3);
        n_tests++; if (bus.o_winVld !== 1'b1) begin n_fail++; $display("FAIL eop_winvld: got %b want 1", bus.o_winVld); end
        n_tests++; if (bus.o_window[NB_WIN +: NB_WIN] !== exp_win(1, 1)) begin n_fail++; $display("FAIL eop_win1: got %h want %h", bus.o_window[NB_WIN +: NB_WIN], exp_win(1, 1)); end
        n_tests++; if (bus.o_blockDone !== 1'b0) begin n_fail++; $display("FAIL eop_blockdone: got %b want 0", bus.o_blockDone); end
        idle();
        n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL eop_after_winvld: got %b want 0", bus.o_winVld); end
        drive(1'b1, 1'b0, 1'b0, 0);
        n_tests++; if (bus.o_colCount !== NB_IMAGE'(1)) begin n_fail++; $display("FAIL eop_restart_colcount: got %0d want 1", bus.o_colCount); end
        drive(1'b1, 1'b0, 1'b0, 1);
        n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL eop_restart_winvld: got %b want 0", bus.o_winVld); end
        drive(1'b1, 1'b0, 1'b0, 2);
        n_tests++; if (bus.o_winVld !== 1'b1) begin n_fail++; $display("FAIL eop_restart_win: got %b want 1", bus.o_winVld); end
        drive(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_short_and_length();
        bus.i_imgLength = NB_IMAGE'(1);
        drive(1'b1, 1'b0, 1'b0, 0);
        n_tests++; if (bus.o_blockDone !== 1'b0) begin n_fail++; $display("FAIL short_done0: got %b want 0", bus.o_blockDone); end
        drive(1'b1, 1'b0, 1'b0, 1);
        n_tests++; if (bus.o_winVld !== 1'b0) begin n_fail++; $display("FAIL short_winvld: got %b want 0", bus.o_winVld); end
        n_tests++; if (bus.o_blockDone !== 1'b1) begin n_fail++; $display("FAIL short_done1: got %b want 1", bus.o_blockDone); end
        n_tests++; if (bus.o_colCount !== NB_IMAGE'(2)) begin n_fail++; $display("FAIL short_colcount: got %0d want 2", bus.o_colCount); end
        idle();
        n_tests++; if (bus.o_blockDone !== 1'b0) begin n_fail++; $display("FAIL short_done_pulse: got %b want 0", bus.o_blockDone); end
        bus.i_imgLength = NB_IMAGE'(4);
        drive(1'b1, 1'b0, 1'b0, 0);
        bus.i_imgLength = NB_IMAGE'(1);
        drive(1'b1, 1'b0, 1'b0, 1);
        n_tests++; if (bus.o_blockDone !== 1'b0) begin n_fail++; $display("FAIL len_hold_done: got %b want 0", bus.o_blockDone); end
        drive(1'b1, 1'b0, 1'b0, 2);
        n_tests++; if (bus.o_winVld !== 1'b1) begin n_fail++; $display("FAIL len_hold_winvld: got %b want 1", bus.o_winVld); end
        drive(1'b1, 1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 1'b0, 4);
        n_tests++; if (bus.o_blockDone !== 1'b1) begin n_fail++; $display("FAIL len_hold_final_done: got %b want 1", bus.o_blockDone); end
        n_tests++; if (bus.o_colCount !== NB_IMAGE'(5)) begin n_fail++; $display("FAIL len_hold_colcount: got %0d want 5", bus.o_colCount); end
        idle();
    endtask

    initial begin
        bus.i_vld         = 1'b0;
        bus.i_changeBlock = 1'b0;
        bus.i_EoP         = 1'b0;
        bus.i_imgLength   = NB_IMAGE'(4);
        bus.i_data        = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_change_block();
        test_eop();
        test_short_and_length();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
